// File: rtl/gmii_rx_ctrl_pkg.sv
// Shared types and constants for the GMII receive control block.
package gmii_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_STAT_WIDTH = 32;

    localparam logic MODE_GMII = 1'b0;
    localparam logic MODE_MII  = 1'b1;

endpackage

// File: rtl/gmii_rx_ctrl_if.sv
// Receiver output beat and status strobes observed by the control block.
interface gmii_rx_ctrl_if;

    logic rx_axis_tvalid;
    logic rx_axis_tlast;
    logic rx_axis_tuser0;
    logic rx_start_packet;
    logic rx_error_bad_frame;
    logic rx_error_bad_fcs;

    modport master (
        output rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser0,
               rx_start_packet, rx_error_bad_frame, rx_error_bad_fcs
    );

    modport slave (
        input  rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser0,
               rx_start_packet, rx_error_bad_frame, rx_error_bad_fcs
    );

endinterface

// File: rtl/eth_stat_counter.sv
// Saturating event counter with snapshot-and-clear; a coincident event reloads 1.
module eth_stat_counter #(
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  latch,
    output logic [STAT_WIDTH-1:0] snap
);

    logic [STAT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            snap <= '0;
        end else if (latch) begin
            snap <= cnt;
            cnt  <= STAT_WIDTH'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gmii_rx_ctrl.sv
// Applies receiver enable/speed requests only at frame boundaries and keeps frame statistics.
module gmii_rx_ctrl
    import gmii_rx_ctrl_pkg::*;
#(
    parameter int unsigned STAT_WIDTH    = DEFAULT_STAT_WIDTH,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_enable,
    input  logic                  req_mii,
    gmii_rx_ctrl_if.slave         mon,
    output logic                  cfg_rx_enable,
    output logic                  mii_select,
    output logic                  active,
    output logic                  drain_timeout,
    input  logic                  stat_latch,
    output logic [STAT_WIDTH-1:0] stat_frames_ok,
    output logic [STAT_WIDTH-1:0] stat_frames_bad,
    output logic [STAT_WIDTH-1:0] stat_fcs_err,
    output logic [STAT_WIDTH-1:0] stat_starts,
    output logic                  stat_valid
);

    localparam int unsigned DW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          timeout_d;
    logic          frame_active;
    logic [DW-1:0] drain_cnt;
    logic          frame_end;
    logic          unused;

    assign frame_end = mon.rx_axis_tvalid & mon.rx_axis_tlast;
    assign unused    = mon.rx_error_bad_frame;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (req_enable && !frame_active) begin
                    mode_d  = req_mii;
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!req_enable || (req_mii != mode_q))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!frame_active) begin
                    state_d = ST_OFF;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_d   = ST_OFF;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Outputs follow the state register, so they settle one cycle after each decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            mode_q        <= MODE_GMII;
            frame_active  <= 1'b0;
            drain_cnt     <= '0;
            cfg_rx_enable <= 1'b0;
            active        <= 1'b0;
            mii_select    <= MODE_GMII;
            drain_timeout <= 1'b0;
            stat_valid    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;

            if (timeout_d)
                frame_active <= 1'b0;
            else if (mon.rx_start_packet)
                frame_active <= 1'b1;
            else if (frame_end)
                frame_active <= 1'b0;

            if (state_q != ST_DRAIN)
                drain_cnt <= '0;
            else if (drain_cnt != DRAIN_LAST)
                drain_cnt <= drain_cnt + 1'b1;

            cfg_rx_enable <= (state_q == ST_ON);
            active        <= (state_q == ST_ON);
            mii_select    <= mode_q;
            drain_timeout <= timeout_d;
            stat_valid    <= stat_latch;
        end
    end

    eth_stat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_frames_ok (
        .clk(clk), .rst(rst), .inc(frame_end & ~mon.rx_axis_tuser0),
        .latch(stat_latch), .snap(stat_frames_ok)
    );

    eth_stat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_frames_bad (
        .clk(clk), .rst(rst), .inc(frame_end & mon.rx_axis_tuser0),
        .latch(stat_latch), .snap(stat_frames_bad)
    );

    eth_stat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_fcs_err (
        .clk(clk), .rst(rst), .inc(mon.rx_error_bad_fcs),
        .latch(stat_latch), .snap(stat_fcs_err)
    );

    eth_stat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_starts (
        .clk(clk), .rst(rst), .inc(mon.rx_start_packet),
        .latch(stat_latch), .snap(stat_starts)
    );

endmodule

// File: tb/tb_gmii_rx_ctrl.sv
// Directed bench for gmii_rx_ctrl: mode sequencing, drain timeout and statistics snapshots.
module tb_gmii_rx_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_enable, req_mii, stat_latch;
    logic         cfg_rx_enable, mii_select, active, drain_timeout, stat_valid;
    logic [W-1:0] stat_frames_ok, stat_frames_bad, stat_fcs_err, stat_starts;

    int n_cmp = 0;
    int n_err = 0;

    gmii_rx_ctrl_if mon ();

    gmii_rx_ctrl #(.STAT_WIDTH(W), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_enable(req_enable), .req_mii(req_mii),
        .mon(mon.slave),
        .cfg_rx_enable(cfg_rx_enable), .mii_select(mii_select),
        .active(active), .drain_timeout(drain_timeout),
        .stat_latch(stat_latch),
        .stat_frames_ok(stat_frames_ok), .stat_frames_bad(stat_frames_bad),
        .stat_fcs_err(stat_fcs_err), .stat_starts(stat_starts),
        .stat_valid(stat_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         tv, tl, tu, sp, fcs, bad, lat;
        logic         exp_valid;
        logic [W-1:0] ok, bd, fc, st;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mon(input logic tv, tl, tu, sp, fcs, bad);
        mon.rx_axis_tvalid     = tv;
        mon.rx_axis_tlast      = tl;
        mon.rx_axis_tuser0     = tu;
        mon.rx_start_packet    = sp;
        mon.rx_error_bad_fcs   = fcs;
        mon.rx_error_bad_frame = bad;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses;

        // tv tl tu sp fcs bad lat | valid ok bad fcs starts
        tbl[0]  = '{0,0,0,1,0,0,0, 0, 1,0,0,2};
        tbl[1]  = '{1,0,0,1,0,0,0, 0, 1,0,0,2};
        tbl[2]  = '{1,1,0,0,0,1,0, 0, 1,0,0,2};
        tbl[3]  = '{0,0,0,1,1,0,0, 0, 1,0,0,2};
        tbl[4]  = '{1,1,1,0,0,0,0, 0, 1,0,0,2};
        tbl[5]  = '{0,0,0,1,0,0,0, 0, 1,0,0,2};
        tbl[6]  = '{1,1,0,0,0,0,0, 0, 1,0,0,2};
        tbl[7]  = '{1,1,1,1,0,0,0, 0, 1,0,0,2};
        tbl[8]  = '{1,1,0,0,0,0,0, 0, 1,0,0,2};
        tbl[9]  = '{0,0,0,0,0,0,1, 1, 3,2,1,5};
        tbl[10] = '{0,0,0,0,0,0,0, 0, 3,2,1,5};
        tbl[11] = '{0,0,0,0,0,0,1, 1, 0,0,0,0};
        tbl[12] = '{1,1,0,0,0,0,1, 1, 0,0,0,0};
        tbl[13] = '{0,0,0,0,0,0,1, 1, 1,0,0,0};
        tbl[14] = '{1,1,1,1,1,0,1, 1, 0,0,0,0};
        tbl[15] = '{0,0,0,0,0,0,1, 1, 0,1,1,1};

        rst = 1'b1; req_enable = 1'b0; req_mii = 1'b0; stat_latch = 1'b0;
        set_mon(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cfg", cfg_rx_enable, 0);
        check("rst_active", active, 0);
        check("rst_mii", mii_select, 0);
        check("rst_timeout", drain_timeout, 0);
        check("rst_valid", stat_valid, 0);
        check("rst_snap", {stat_frames_ok, stat_frames_bad, stat_fcs_err, stat_starts}, 0);

        // Enable in byte mode: outputs rise on the second edge.
        req_enable = 1'b1;
        tick();
        check("en_lag_active", active, 0);
        tick();
        check("en_cfg", cfg_rx_enable, 1);
        check("en_active", active, 1);
        check("en_mii", mii_select, 0);

        // Speed change mid-frame waits for tlast, then goes through OFF.
        set_mon(0, 0, 0, 1, 0, 0);
        tick();
        set_mon(0, 0, 0, 0, 0, 0);
        req_mii = 1'b1;
        tick();
        tick();
        check("chg_cfg_off", cfg_rx_enable, 0);
        check("chg_mii_hold", mii_select, 0);
        repeat (4) tick();
        check("chg_still_drain", active, 0);
        check("chg_mii_hold2", mii_select, 0);
        set_mon(1, 1, 0, 0, 0, 0);
        tick();
        set_mon(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("chg_via_off", active, 0);
        tick();
        check("chg_on", active, 1);
        check("chg_cfg_on", cfg_rx_enable, 1);
        check("chg_mii_new", mii_select, 1);

        // Disable mid-frame with no tlast: drain must time out 16 cycles after DRAIN entry.
        set_mon(0, 0, 0, 1, 0, 0);
        tick();
        set_mon(0, 0, 0, 0, 0, 0);
        req_enable = 1'b0;
        tick();
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (drain_timeout) break;
        end
        check("to_latency", n, 16);
        pulses = 0;
        repeat (8) begin
            tick();
            if (drain_timeout) pulses++;
        end
        check("to_single_pulse", pulses, 0);
        check("to_off", active, 0);
        req_enable = 1'b1;
        tick();
        tick();
        check("to_frame_cleared", active, 1);
        check("to_mii", mii_select, 1);

        // Flush events so far: 1 good frame, 2 starts.
        stat_latch = 1'b1;
        tick();
        stat_latch = 1'b0;
        check("pre_valid", stat_valid, 1);
        check("pre_snap", {stat_frames_ok, stat_frames_bad, stat_fcs_err, stat_starts}, {4'd1, 4'd0, 4'd0, 4'd2});
        tick();
        check("pre_valid_drop", stat_valid, 0);

        foreach (tbl[i]) begin
            set_mon(tbl[i].tv, tbl[i].tl, tbl[i].tu, tbl[i].sp, tbl[i].fcs, tbl[i].bad);
            stat_latch = tbl[i].lat;
            tick();
            check($sformatf("v%0d_valid", i), stat_valid, tbl[i].exp_valid);
            check($sformatf("v%0d_ok", i), stat_frames_ok, tbl[i].ok);
            check($sformatf("v%0d_bad", i), stat_frames_bad, tbl[i].bd);
            check($sformatf("v%0d_fcs", i), stat_fcs_err, tbl[i].fc);
            check($sformatf("v%0d_starts", i), stat_starts, tbl[i].st);
        end
        set_mon(0, 0, 0, 0, 0, 0);
        stat_latch = 1'b0;

        // 20 good frames into a 4-bit counter saturate at 15.
        set_mon(1, 1, 0, 0, 0, 0);
        repeat (20) tick();
        set_mon(0, 0, 0, 0, 0, 0);
        stat_latch = 1'b1;
        tick();
        check("sat_ok", stat_frames_ok, 15);
        tick();
        stat_latch = 1'b0;
        check("sat_cleared", stat_frames_ok, 0);

        // Start and tlast together keep the frame open; a 1->0->1 request still drains via OFF.
        set_mon(1, 1, 0, 1, 0, 0);
        tick();
        set_mon(0, 0, 0, 0, 0, 0);
        req_enable = 1'b0;
        tick();
        tick();
        check("sw_drain", active, 0);
        req_enable = 1'b1;
        repeat (6) tick();
        check("sw_set_wins", active, 0);
        set_mon(1, 1, 0, 0, 0, 0);
        tick();
        set_mon(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("sw_back_on", active, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
